addn_pipe: RTL and testbench

- Parametrised, pipelined N-bit adder; successor to the 1-bit RTL adder.
- Computes {co, sum} = a + b + ci over WIDTH bits, split into STAGES carry-chained slices with one register stage per slice.
- Uses a valid/ready handshake on both sides with full backpressure.
- Used as the datapath element in the adder test benches and in downstream arithmetic blocks.

---
 rtl/addn_pipe.sv | 129 ++++++++++++
 tb/tb_addn_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addn_pipe.sv
// rtl/addn_pipe.sv - pipelined WIDTH-bit adder, STAGES carry-chained slices, valid/ready
// Optional change counter on the output stream: ADDN_PIPE_CHANGE_CNT_EN
module addn_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef ADDN_PIPE_CHANGE_CNT_EN
   ,
   output logic [15:0]      chg_cnt
`endif
);

   localparam int SW = WIDTH / STAGES;

   logic [STAGES-1:0]            valid_q, valid_d;
   logic [STAGES-1:0]            carry_q, carry_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic                         stall;

   // Entry k of each chain is what stage k consumes; entry 0 is the input port.
   logic [STAGES:0]              v_chain, c_chain;
   logic [STAGES:0][WIDTH-1:0]   a_chain, b_chain, s_chain;
   logic [STAGES-1:0][SW:0]      slice;

   assign v_chain = {valid_q, in_valid};
   assign c_chain = {carry_q, ci};
   assign a_chain = {a_q, a};
   assign b_chain = {b_q, b};
   assign s_chain = {s_q, {WIDTH{1'b0}}};

   for (genvar g = 0; g < STAGES; g++) begin : g_slice
      assign slice[g] = {1'b0, a_chain[g][g*SW +: SW]}
                      + {1'b0, b_chain[g][g*SW +: SW]}
                      + (SW+1)'(c_chain[g]);
   end

   assign stall     = valid_q[STAGES-1] && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = valid_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign co        = carry_q[STAGES-1];

   // Data registers load only behind a valid token, so bubbles never disturb held results.
   always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = v_chain[k];
            if (v_chain[k]) begin
               a_d[k]               = a_chain[k];
               b_d[k]               = b_chain[k];
               s_d[k]               = s_chain[k];
               s_d[k][k*SW +: SW]   = slice[k][SW-1:0];
               carry_d[k]           = slice[k][SW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         carry_q <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
      end
   end

   logic unused_tail;
   assign unused_tail = ^{a_chain[STAGES], b_chain[STAGES], s_chain[STAGES],
                          c_chain[STAGES], v_chain[STAGES]};

`ifdef ADDN_PIPE_CHANGE_CNT_EN
   logic [15:0]    cnt_q, cnt_d;
   logic [WIDTH:0] last_q, last_d;
   logic           seen_q, seen_d;

   // The first transfer after reset has no predecessor and always counts.
   always_comb begin
      cnt_d  = cnt_q;
      last_d = last_q;
      seen_d = seen_q;
      if (out_valid && out_ready) begin
         if (!seen_q || ({co, sum} != last_q)) begin
            cnt_d = cnt_q + 16'd1;
         end
         last_d = {co, sum};
         seen_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         last_q <= '0;
         seen_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         last_q <= last_d;
         seen_q <= seen_d;
      end
   end

   assign chg_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_addn_pipe.sv
// tb/tb_addn_pipe.sv - randomized and directed checks of addn_pipe against an arithmetic scoreboard
module tb_addn_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       iv, ir, ov, ordy, ci, co;
   logic [7:0] a, b, sum;
   logic       iv3, ir3, ov3, ordy3, ci3, co3;
   logic [2:0] a3, b3, sum3;
`ifdef ADDN_PIPE_CHANGE_CNT_EN
   logic [15:0] chg_cnt, chg_cnt3;
`endif

   addn_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .ci(ci),
      .out_valid(ov), .out_ready(ordy), .sum(sum), .co(co)
`ifdef ADDN_PIPE_CHANGE_CNT_EN
      , .chg_cnt(chg_cnt)
`endif
   );

   addn_pipe #(.WIDTH(3), .STAGES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .ci(ci3),
      .out_valid(ov3), .out_ready(ordy3), .sum(sum3), .co(co3)
`ifdef ADDN_PIPE_CHANGE_CNT_EN
      , .chg_cnt(chg_cnt3)
`endif
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [8:0] r;
      int         c;
   } item_t;

   item_t      q8[$];
   item_t      q3[$];
   int         n_out8 = 0;
   int         n_out3 = 0;
   bit         lat_chk8;
   bit         hold_v;
   logic [8:0] hold_r;
   int         cnt_m;
   bit         seen_m;
   logic [8:0] last_m;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard for the 8-bit pipe: values observed at negedge decide the transfers of the next posedge.
   always @(negedge clk) begin : mon8
      item_t it;
      if (!rst_n) begin
         q8.delete();
         hold_v = 1'b0;
         cnt_m  = 0;
         seen_m = 1'b0;
         check("rst_ov8", 32'(ov), 32'(0));
      end else begin
         check("in_ready8", 32'(ir), 32'(!(ov && !ordy)));
         if (q8.size() == 0) check("idle_ov8", 32'(ov), 32'(0));
         if (hold_v) check("hold8", 32'({co, sum}), 32'(hold_r));
`ifdef ADDN_PIPE_CHANGE_CNT_EN
         check("chg_cnt", 32'(chg_cnt), 32'(cnt_m[15:0]));
`endif
         if (ov && ordy && q8.size() != 0) begin
            it = q8.pop_front();
            n_out8++;
            check("res8", 32'({co, sum}), 32'(it.r));
            if (lat_chk8) check("lat8", 32'(cyc - it.c), 32'(2));
            if (!seen_m || it.r != last_m) cnt_m++;
            seen_m = 1'b1;
            last_m = it.r;
         end
         hold_v = ov && !ordy;
         hold_r = {co, sum};
         if (iv && ir) q8.push_back('{r: 9'(a) + 9'(b) + 9'(ci), c: cyc});
      end
   end

   always @(negedge clk) begin : mon3
      item_t it;
      if (!rst_n) begin
         q3.delete();
      end else begin
         if (q3.size() == 0) check("idle_ov3", 32'(ov3), 32'(0));
         if (ov3 && ordy3 && q3.size() != 0) begin
            it = q3.pop_front();
            n_out3++;
            check("res3", 32'({co3, sum3}), 32'(it.r));
            check("lat3", 32'(cyc - it.c), 32'(3));
         end
         if (iv3 && ir3) q3.push_back('{r: 9'(a3) + 9'(b3) + 9'(ci3), c: cyc});
      end
   end

   task automatic drive8(input logic [7:0] x, input logic [7:0] y, input logic c);
      bit acc;
      acc = 1'b0;
      a = x; b = y; ci = c; iv = 1'b1;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = ir;
         @(posedge clk); #1;
      end
      check("accept8", 32'(acc), 32'(1));
      iv = 1'b0;
   endtask

   task automatic drain8();
      ordy = 1'b1;
      iv   = 1'b0;
      for (int t = 0; t < 50 && q8.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      check("drain8", 32'(q8.size()), 32'(0));
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int n0;
      rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; a = '0; b = '0; ci = 1'b0;
      iv3 = 1'b0; ordy3 = 1'b1; a3 = '0; b3 = '0; ci3 = 1'b0;
      lat_chk8 = 1'b1;

      // Reset holds outputs quiet whatever the inputs do.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); iv = 1'($urandom);
         a3 = 3'($urandom); b3 = 3'($urandom); ci3 = 1'($urandom); iv3 = 1'($urandom);
         ordy = 1'($urandom);
         @(negedge clk);
         check("rst_sum", 32'(sum), 32'(0));
         check("rst_co", 32'(co), 32'(0));
         check("rst_in_ready", 32'(ir), 32'(1));
         check("rst_ov3", 32'(ov3), 32'(0));
         check("rst_sum3", 32'(sum3), 32'(0));
      end
      @(posedge clk); #1;
      iv = 1'b0; iv3 = 1'b0; ordy = 1'b1;
      rst_n = 1'b1;

      // First result appears after two edges.
      a = 8'h03; b = 8'h05; ci = 1'b0; iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      @(negedge clk);
      check("first_ov_early", 32'(ov), 32'(0));
      @(negedge clk);
      check("first_ov", 32'(ov), 32'(1));
      check("first_sum", 32'(sum), 32'(8'h08));
      check("first_co", 32'(co), 32'(0));
      @(posedge clk); #1;

      drive8(8'h0F, 8'h01, 1'b0);
      drive8(8'hFF, 8'h00, 1'b1);
      drive8(8'hFF, 8'hFF, 1'b1);
      drain8();

      // Every (a,b,ci) of the 3-bit, 3-stage pipe, back to back.
      for (int i = 0; i < 128; i++) begin
         a3 = i[2:0]; b3 = i[5:3]; ci3 = i[6]; iv3 = 1'b1;
         @(posedge clk); #1;
      end
      iv3 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("n_out3", 32'(n_out3), 32'(128));

      // Backpressure in the middle of a six-operand stream.
      lat_chk8 = 1'b0;
      n0 = n_out8;
      fork
         begin
            for (int i = 0; i < 6; i++) drive8(8'($urandom), 8'($urandom), 1'($urandom));
         end
         begin
            repeat (3) @(posedge clk);
            #1 ordy = 1'b0;
            repeat (4) @(posedge clk);
            #1 ordy = 1'b1;
         end
      join
      drain8();
      check("bp_count", 32'(n_out8 - n0), 32'(6));

      // Reset with two results in flight discards them.
      lat_chk8 = 1'b1;
      drive8(8'h11, 8'h22, 1'b0);
      drive8(8'h33, 8'h44, 1'b1);
      pulse_reset();
      repeat (5) @(posedge clk);
      #1;
      drive8(8'h80, 8'h7F, 1'b1);
      drain8();

      // Results 5, 5, 7, 7, 5.
      pulse_reset();
      drive8(8'h05, 8'h00, 1'b0);
      drive8(8'h02, 8'h03, 1'b0);
      drive8(8'h07, 8'h00, 1'b0);
      drive8(8'h03, 8'h03, 1'b1);
      drive8(8'h01, 8'h04, 1'b0);
      drain8();
      @(posedge clk); #1;
`ifdef ADDN_PIPE_CHANGE_CNT_EN
      check("chg_cnt_final", 32'(chg_cnt), 32'(3));
`endif

      // Random traffic on both sides.
      lat_chk8 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         iv   = ($urandom_range(3) != 0);
         a    = 8'($urandom);
         b    = 8'($urandom);
         ci   = 1'($urandom);
         ordy = ($urandom_range(3) != 0);
         @(posedge clk); #1;
      end
      drain8();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
